// File: rtl/cndm_micro_pkg.sv
// Shared MSI definitions for the cndm_micro interrupt path.
// Holds the vector width and the multiple-message-enable decode.
package cndm_micro_pkg;

    localparam int unsigned MSI_VEC_W = 32;
    localparam int unsigned MSI_IDX_W = 5;

    // Vector mask from log2 of the host-enabled vector count, capped at 32 vectors.
    function automatic logic [MSI_IDX_W-1:0] msi_vec_mask(input logic [2:0] mmenable);
        logic [2:0] m;
        m = (mmenable > 3'd5) ? 3'd5 : mmenable;
        return MSI_IDX_W'((6'd1 << m) - 6'd1);
    endfunction

endpackage

// File: rtl/cndm_micro_rr_arb.sv
// Round-robin grant over IRQ_CNT requests; ptr is the highest-priority index.
// A ptr at or beyond IRQ_CNT falls through to the lowest request, giving the wrap.
module cndm_micro_rr_arb
    import cndm_micro_pkg::*;
#(
    parameter int unsigned IRQ_CNT = 32
) (
    input  logic [IRQ_CNT-1:0]   req,
    input  logic [MSI_IDX_W-1:0] ptr,
    output logic                 valid,
    output logic [MSI_IDX_W-1:0] grant_idx,
    output logic [IRQ_CNT-1:0]   grant
);

    logic [IRQ_CNT-1:0]   hi_req;
    logic [MSI_IDX_W-1:0] hi_idx;
    logic [MSI_IDX_W-1:0] lo_idx;

    always_comb begin
        hi_req = '0;
        hi_idx = '0;
        lo_idx = '0;
        grant  = '0;
        for (int i = 0; i < IRQ_CNT; i++) begin
            hi_req[i] = req[i] && (MSI_IDX_W'(i) >= ptr);
        end
        for (int i = IRQ_CNT - 1; i >= 0; i--) begin
            if (hi_req[i]) hi_idx = MSI_IDX_W'(i);
            if (req[i])    lo_idx = MSI_IDX_W'(i);
        end
        valid     = |req;
        grant_idx = (|hi_req) ? hi_idx : lo_idx;
        for (int i = 0; i < IRQ_CNT; i++) begin
            grant[i] = valid && (MSI_IDX_W'(i) == grant_idx);
        end
    end

endmodule

// File: rtl/cndm_micro_msi_ctrl.sv
// MSI interrupt controller: latches IRQ pulses, issues one MSI at a time to the
// PCIe core, and retries after a backoff on fail or timeout.
module cndm_micro_msi_ctrl
    import cndm_micro_pkg::*;
#(
    parameter int unsigned IRQ_CNT     = 32,
    parameter int unsigned BACKOFF_CYC = 64,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IRQ_CNT-1:0]   irq,
    input  logic [3:0]           cfg_interrupt_msi_enable,
    input  logic [11:0]          cfg_interrupt_msi_mmenable,
    output logic [MSI_VEC_W-1:0] cfg_interrupt_msi_int,
    input  logic                 cfg_interrupt_msi_sent,
    input  logic                 cfg_interrupt_msi_fail,
    output logic [7:0]           cfg_interrupt_msi_function_number,
    output logic [2:0]           cfg_interrupt_msi_attr,
    output logic                 cfg_interrupt_msi_tph_present,
    output logic [1:0]           cfg_interrupt_msi_tph_type,
    output logic [7:0]           cfg_interrupt_msi_tph_st_tag,
    output logic [1:0]           cfg_interrupt_msi_select,
    output logic [31:0]          cfg_interrupt_msi_pending_status,
    output logic                 cfg_interrupt_msi_pending_status_data_enable,
    output logic [1:0]           cfg_interrupt_msi_pending_status_function_num,
    output logic                 busy,
    output logic                 stat_sent,
    output logic                 stat_fail,
    output logic                 stat_timeout
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StBackoff} state_e;

    state_e               state_q, state_d;
    logic [IRQ_CNT-1:0]   pending_q, pending_d, arb_grant, retry_set;
    logic [MSI_IDX_W-1:0] ptr_q, ptr_d, idx_q, idx_d, vec_q, vec_d, arb_idx;
    logic [31:0]          cnt_q, cnt_d;
    logic                 sent_q, sent_d, fail_q, fail_d, tmo_q, tmo_d;
    logic                 arb_valid, grant_en, retry;
    logic                 unused_cfg;

    assign unused_cfg = ^{cfg_interrupt_msi_enable[3:1], cfg_interrupt_msi_mmenable[11:3]};

    cndm_micro_rr_arb #(
        .IRQ_CNT(IRQ_CNT)
    ) u_rr_arb (
        .req      (pending_q),
        .ptr      (ptr_q),
        .valid    (arb_valid),
        .grant_idx(arb_idx),
        .grant    (arb_grant)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        vec_d     = vec_q;
        cnt_d     = cnt_q;
        sent_d    = 1'b0;
        fail_d    = 1'b0;
        tmo_d     = 1'b0;
        grant_en  = 1'b0;
        retry     = 1'b0;
        retry_set = '0;
        unique case (state_q)
            StIdle: begin
                if (cfg_interrupt_msi_enable[0] && arb_valid) begin
                    grant_en = 1'b1;
                    idx_d    = arb_idx;
                    vec_d    = arb_idx & msi_vec_mask(cfg_interrupt_msi_mmenable[2:0]);
                    ptr_d    = arb_idx + MSI_IDX_W'(1);
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = 32'(TIMEOUT_CYC - 1);
                state_d = StWait;
            end
            StWait: begin
                // sent beats a same-cycle fail; timeout is treated as a fail
                if (cfg_interrupt_msi_sent) begin
                    sent_d  = 1'b1;
                    state_d = StIdle;
                end else if (cfg_interrupt_msi_fail || cnt_q == '0) begin
                    retry   = 1'b1;
                    fail_d  = cfg_interrupt_msi_fail;
                    tmo_d   = !cfg_interrupt_msi_fail;
                    cnt_d   = 32'(BACKOFF_CYC - 1);
                    state_d = StBackoff;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            StBackoff: begin
                if (cnt_q == '0) state_d = StIdle;
                else             cnt_d   = cnt_q - 32'd1;
            end
            default: state_d = StIdle;
        endcase
        for (int i = 0; i < IRQ_CNT; i++) begin
            retry_set[i] = retry && (MSI_IDX_W'(i) == idx_q);
        end
        // New requests are OR'd in after the clear so a same-cycle pulse is never lost
        pending_d = (pending_q & ~(grant_en ? arb_grant : '0)) | irq | retry_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            pending_q <= '0;
            ptr_q     <= '0;
            idx_q     <= '0;
            vec_q     <= '0;
            cnt_q     <= '0;
            sent_q    <= 1'b0;
            fail_q    <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            vec_q     <= vec_d;
            cnt_q     <= cnt_d;
            sent_q    <= sent_d;
            fail_q    <= fail_d;
            tmo_q     <= tmo_d;
        end
    end

    assign cfg_interrupt_msi_int = (state_q == StIssue) ? (MSI_VEC_W'(1) << vec_q) : '0;
    assign busy                  = (state_q != StIdle);
    assign stat_sent             = sent_q;
    assign stat_fail             = fail_q;
    assign stat_timeout          = tmo_q;

    assign cfg_interrupt_msi_function_number             = '0;
    assign cfg_interrupt_msi_attr                        = '0;
    assign cfg_interrupt_msi_tph_present                 = 1'b0;
    assign cfg_interrupt_msi_tph_type                    = '0;
    assign cfg_interrupt_msi_tph_st_tag                  = '0;
    assign cfg_interrupt_msi_select                      = '0;
    assign cfg_interrupt_msi_pending_status              = '0;
    assign cfg_interrupt_msi_pending_status_data_enable  = 1'b0;
    assign cfg_interrupt_msi_pending_status_function_num = '0;

endmodule

// File: tb/tb_cndm_micro_msi_ctrl.sv
// Directed bench for cndm_micro_msi_ctrl; expected MSI vectors are queued when
// IRQs are driven and checked by a monitor as the controller issues them.
module tb_cndm_micro_msi_ctrl;

    localparam int unsigned IRQ_CNT = 8;
    localparam int unsigned BACKOFF = 8;
    localparam int unsigned TIMEOUT = 40;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   irq;
    logic [3:0]   msi_en;
    logic [11:0]  mmen;
    logic [31:0]  msi_int;
    logic         sent, fail;
    logic [7:0]   fn_num, st_tag;
    logic [2:0]   attr;
    logic         tph_present, pend_de;
    logic [1:0]   tph_type, sel, pend_fn;
    logic [31:0]  pend_status;
    logic         busy, stat_sent, stat_fail, stat_timeout;

    int checks = 0, failures = 0;
    int msi_cnt = 0, sent_cnt = 0, fail_cnt = 0, tmo_cnt = 0;
    bit mon_en = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    always #5 clk = ~clk;

    cndm_micro_msi_ctrl #(
        .IRQ_CNT    (IRQ_CNT),
        .BACKOFF_CYC(BACKOFF),
        .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .clk                                          (clk),
        .rst                                          (rst),
        .irq                                          (irq),
        .cfg_interrupt_msi_enable                     (msi_en),
        .cfg_interrupt_msi_mmenable                   (mmen),
        .cfg_interrupt_msi_int                        (msi_int),
        .cfg_interrupt_msi_sent                       (sent),
        .cfg_interrupt_msi_fail                       (fail),
        .cfg_interrupt_msi_function_number            (fn_num),
        .cfg_interrupt_msi_attr                       (attr),
        .cfg_interrupt_msi_tph_present                (tph_present),
        .cfg_interrupt_msi_tph_type                   (tph_type),
        .cfg_interrupt_msi_tph_st_tag                 (st_tag),
        .cfg_interrupt_msi_select                     (sel),
        .cfg_interrupt_msi_pending_status             (pend_status),
        .cfg_interrupt_msi_pending_status_data_enable (pend_de),
        .cfg_interrupt_msi_pending_status_function_num(pend_fn),
        .busy                                         (busy),
        .stat_sent                                    (stat_sent),
        .stat_fail                                    (stat_fail),
        .stat_timeout                                 (stat_timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every nonzero msi_int cycle must match the next queued vector
    always @(negedge clk) begin
        if (mon_en) begin
            if (msi_int !== 32'h0) begin
                msi_cnt++;
                if (exp_q.size() == 0) begin
                    check("msi_unexpected", msi_int, 32'h0);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("msi_vector", msi_int, exp_v);
                end
            end
            if (stat_sent === 1'b1)    sent_cnt++;
            if (stat_fail === 1'b1)    fail_cnt++;
            if (stat_timeout === 1'b1) tmo_cnt++;
        end
    end

    task automatic cycle(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_irq(input logic [7:0] m);
        irq = m;
        cycle(1);
        irq = '0;
    endtask

    task automatic wait_msi(input string tag, input int budget, output int waited);
        int start;
        start  = msi_cnt;
        waited = 0;
        while (msi_cnt == start && waited < budget) begin
            cycle(1);
            waited++;
        end
        check({tag, "_seen"}, 32'(msi_cnt != start), 32'd1);
    endtask

    task automatic respond_sent(input int d);
        cycle(d);
        sent = 1'b1;
        cycle(1);
        sent = 1'b0;
    endtask

    task automatic respond_fail(input int d);
        cycle(d);
        fail = 1'b1;
        cycle(1);
        fail = 1'b0;
    endtask

    initial begin
        int w, s0, f0, t0, m0;
        rst = 1'b1; irq = '0; sent = 1'b0; fail = 1'b0; msi_en = 4'h1; mmen = 12'd5;
        cycle(3);
        check("rst_msi_int", msi_int, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stats", 32'({stat_sent, stat_fail, stat_timeout}), 32'd0);
        rst = 1'b0; mon_en = 1'b1;
        cycle(2);
        check("idle_busy", 32'(busy), 32'd0);

        // irq[5], full vector space: 0x20 two cycles after the pulse
        s0 = sent_cnt;
        exp_q.push_back(32'h20);
        pulse_irq(8'h20);
        wait_msi("irq5", 10, w);
        check("irq5_latency", 32'(w), 32'd1);
        check("irq5_busy", 32'(busy), 32'd1);
        respond_sent(3);
        cycle(2);
        check("irq5_stat_sent", 32'(sent_cnt - s0), 32'd1);
        check("irq5_busy_after", 32'(busy), 32'd0);

        // two sources in one cycle, twice: order 0 then 4 both times (pointer wrap)
        s0 = sent_cnt;
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(32'h1);
            exp_q.push_back(32'h10);
            pulse_irq(8'h11);
            wait_msi("rr_a", 10, w);
            respond_sent(1);
            wait_msi("rr_b", 10, w);
            respond_sent(1);
        end
        cycle(2);
        check("rr_sent_count", 32'(sent_cnt - s0), 32'd4);

        // 4 vectors enabled: source 6 folds onto vector 2
        mmen = 12'd2;
        exp_q.push_back(32'h4);
        pulse_irq(8'h40);
        wait_msi("mm2", 10, w);
        respond_sent(1);
        mmen = 12'd5;
        cycle(2);

        // fail then retry after backoff with the same vector
        s0 = sent_cnt; f0 = fail_cnt;
        exp_q.push_back(32'h80);
        pulse_irq(8'h80);
        wait_msi("fail_first", 10, w);
        exp_q.push_back(32'h80);
        respond_fail(1);
        check("fail_stat", 32'(fail_cnt - f0), 32'd1);
        check("fail_busy_backoff", 32'(busy), 32'd1);
        wait_msi("fail_retry", 30, w);
        check("fail_retry_delay", 32'(w), 32'(BACKOFF + 1));
        respond_sent(1);
        cycle(2);
        check("fail_then_sent", 32'(sent_cnt - s0), 32'd1);
        check("fail_count_final", 32'(fail_cnt - f0), 32'd1);

        // timeout then retry; reset mid-wait abandons the retry
        t0 = tmo_cnt;
        exp_q.push_back(32'h4);
        pulse_irq(8'h04);
        wait_msi("tmo_first", 10, w);
        exp_q.push_back(32'h4);
        wait_msi("tmo_retry", int'(TIMEOUT + BACKOFF) + 20, w);
        check("tmo_retry_delay", 32'(w), 32'(TIMEOUT + BACKOFF + 2));
        check("tmo_stat", 32'(tmo_cnt - t0), 32'd1);
        m0 = msi_cnt;
        cycle(3);
        rst = 1'b1;
        cycle(2);
        check("rst_wait_msi_int", msi_int, 32'h0);
        check("rst_wait_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        cycle(int'(TIMEOUT + BACKOFF) + 10);
        check("rst_no_retry", 32'(msi_cnt - m0), 32'd0);
        check("rst_no_timeout", 32'(tmo_cnt - t0), 32'd1);
        check("rst_queue_empty", 32'(exp_q.size()), 32'd0);

        // MSI disabled: request held, issued once enable rises
        msi_en = 4'h0;
        m0 = msi_cnt;
        pulse_irq(8'h08);
        cycle(10);
        check("dis_no_msi", 32'(msi_cnt - m0), 32'd0);
        exp_q.push_back(32'h8);
        msi_en = 4'h1;
        wait_msi("en_rise", 5, w);
        check("en_rise_latency", 32'(w >= 1 && w <= 2), 32'd1);
        respond_sent(1);
        cycle(2);

        // sent and fail together: sent wins, no retry
        s0 = sent_cnt; f0 = fail_cnt;
        exp_q.push_back(32'h2);
        pulse_irq(8'h02);
        wait_msi("prio", 10, w);
        m0 = msi_cnt;
        cycle(1);
        sent = 1'b1; fail = 1'b1;
        cycle(1);
        sent = 1'b0; fail = 1'b0;
        cycle(int'(BACKOFF) + 5);
        check("prio_sent", 32'(sent_cnt - s0), 32'd1);
        check("prio_no_fail", 32'(fail_cnt - f0), 32'd0);
        check("prio_no_retry", 32'(msi_cnt - m0), 32'd0);
        check("prio_busy", 32'(busy), 32'd0);

        // strobes while idle are ignored
        s0 = sent_cnt; f0 = fail_cnt;
        sent = 1'b1; fail = 1'b1;
        cycle(1);
        sent = 1'b0; fail = 1'b0;
        cycle(2);
        check("idle_strobes", 32'((sent_cnt - s0) + (fail_cnt - f0)), 32'd0);
        check("idle_strobes_busy", 32'(busy), 32'd0);

        // irq repeated in the grant cycle must survive the clear
        m0 = msi_cnt;
        exp_q.push_back(32'h10);
        exp_q.push_back(32'h10);
        irq = 8'h10;
        cycle(2);
        irq = '0;
        check("setwin_first", 32'(msi_cnt - m0), 32'd1);
        respond_sent(1);
        wait_msi("setwin_second", 10, w);
        respond_sent(1);
        cycle(2);
        check("setwin_queue_empty", 32'(exp_q.size()), 32'd0);

        check("const_outputs", 32'(|{fn_num, attr, tph_present, tph_type, st_tag, sel,
                                     pend_status, pend_de, pend_fn}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cndm_micro_msi_ctrl.md
CNDM_MICRO_MSI_CTRL -- requirements
Module: cndm_micro_msi_ctrl

Interface
REQ-001 SHALL have parameter IRQ_CNT, default 32, number of interrupt sources (1..32).
REQ-002 SHALL have parameter BACKOFF_CYC, default 64, idle cycles after a failed or timed-out message before retry.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 4096, maximum cycles to wait for sent/fail.
REQ-004 SHALL have port clk, input, 1, single clock; all logic synchronous to its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port irq, input, IRQ_CNT, one-cycle request pulses; bit i = source i.
REQ-007 SHALL have port cfg_interrupt_msi_enable, input, 4, bit 0 = function 0 MSI enabled.
REQ-008 SHALL have port cfg_interrupt_msi_mmenable, input, 12, bits [2:0] = log2 of enabled vector count.
REQ-009 SHALL have port cfg_interrupt_msi_int, output, 32, one-hot MSI request to the PCIe core.
REQ-010 SHALL have port cfg_interrupt_msi_sent, input, 1, core message-sent strobe.
REQ-011 SHALL have port cfg_interrupt_msi_fail, input, 1, core message-fail strobe.
REQ-012 SHALL have outputs cfg_interrupt_msi_function_number (8), _attr (3), _tph_present (1), _tph_type (2), _tph_st_tag (8), _select (2), _pending_status (32), _pending_status_data_enable (1), _pending_status_function_num (2), all constant 0.
REQ-013 SHALL have port busy, output, 1, high whenever the FSM is not IDLE.
REQ-014 SHALL have ports stat_sent, stat_fail, stat_timeout, output, 1 each, one-cycle event pulses.

Function
REQ-015 SHALL keep an IRQ_CNT-bit pending register; irq bit set in cycle n makes pending set from cycle n+1.
REQ-016 SHALL let a set request win over a same-cycle clear of the same pending bit (no lost interrupt).
REQ-017 SHALL map source i to vector i & ((1<<m)-1), m = min(mmenable[2:0],5).
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT, BACKOFF.
REQ-019 IDLE: if msi_enable[0]=1 and pending!=0, SHALL grant one source round-robin, starting at the index after the last grant, clear its pending bit, latch its vector, and go to ISSUE.
REQ-020 ISSUE: SHALL drive cfg_interrupt_msi_int = 1<<vector for exactly one cycle, then go to WAIT; msi_int SHALL be 0 in every other state.
REQ-021 Latency: irq pulse in cycle n with FSM IDLE and MSI enabled SHALL produce msi_int in cycle n+2.
REQ-022 WAIT: on sent SHALL pulse stat_sent and return to IDLE; sent SHALL take priority over a same-cycle fail.
REQ-023 WAIT: on fail SHALL re-set the granted pending bit, pulse stat_fail, load the backoff counter, and enter BACKOFF.
REQ-024 WAIT: after TIMEOUT_CYC cycles without sent/fail SHALL behave as fail but pulse stat_timeout instead of stat_fail.
REQ-025 BACKOFF: SHALL count BACKOFF_CYC cycles, then return to IDLE.
REQ-026 SHALL retain pending bits while msi_enable[0]=0 and issue nothing new; an in-flight message SHALL complete normally.
REQ-027 SHALL have at most one message outstanding.
REQ-028 SHALL ignore sent/fail strobes outside WAIT.

Reset
REQ-029 On rst SHALL clear pending, set FSM to IDLE, zero all counters, set the round-robin pointer so that source 0 wins first, and drive all outputs 0.
REQ-030 rst during WAIT or BACKOFF SHALL abandon the message without retry.

Structure
REQ-031 SHALL place MSI vector width (32) and the mmenable-to-mask decode function in shared package cndm_micro_pkg; the FSM state enum SHALL stay local.
REQ-032 SHALL use one sub-module, cndm_micro_rr_arb (IRQ_CNT-wide round-robin grant with a priority-rotate pointer).

Verification
REQ-033 irq[5] pulse, mmenable=5, sent 3 cycles after ISSUE -> msi_int=0x20 exactly 2 cycles after irq, stat_sent pulse, busy low afterwards.
REQ-034 irq=0x0000_0011 in one cycle -> messages 0x1 then 0x10 in that order; next irq=0x11 -> 0x1 then 0x10 again (pointer wrap).
REQ-035 mmenable=2, irq[6] -> msi_int=0x4.
REQ-036 fail strobe on first attempt -> stat_fail, BACKOFF_CYC idle cycles, retry with same vector, then sent -> single stat_sent.
REQ-037 no sent/fail for TIMEOUT_CYC cycles -> stat_timeout, retry after backoff; rst asserted mid-WAIT -> pending 0, msi_int 0, no retry.
REQ-038 msi_enable[0]=0, irq[3] pulse -> no msi_int; enable raised 10 cycles later -> msi_int=0x8 within 2 cycles.
